// File: rtl/lux_pkg.sv
// lux_pkg: shared types and constants for the lux sensor SPI reader
package lux_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;
  localparam int LUX_W = 16;
  localparam int FRAME_BITS = 16;
  localparam int AVG_FRAMES = 4;
  localparam int ACC_W = 18;
endpackage

// File: rtl/lux_spi_reader_sync_2ff.sv
// sync_2ff: two-flop synchronizer; ports clk, rst_n (sync, active-low), d (async in), q (synchronized out)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk)
    if (!rst_n) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/lux_spi_reader.sv
// lux_spi_reader: periodic SPI mode-0 master reading 16-bit lux samples into a lux_out/data_valid stream
// ports: clk, rst_n (sync, active-low), enable, spi_miso in; spi_sclk, spi_cs_n, lux_out, data_valid, busy out
// LUX_SPI_AVG_EN: when defined, lux_out carries the truncated mean of every 4 frames instead of each raw frame
module lux_spi_reader
  import lux_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int SAMPLE_PERIOD = 100000,
  parameter int CS_SETUP = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             spi_miso,
  output logic             spi_sclk,
  output logic             spi_cs_n,
  output logic [LUX_W-1:0] lux_out,
  output logic             data_valid,
  output logic             busy
);
  localparam int CW = $clog2((2 * CLK_DIV > CS_SETUP ? 2 * CLK_DIV : CS_SETUP) + 1);
  localparam int TW = $clog2(SAMPLE_PERIOD + 1);
  localparam int DW = $clog2(CS_SETUP + 1);
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] SETUP_END = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV);
  localparam logic [CW-1:0] BIT_END = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_END = CW'(CLK_DIV - 1);
  localparam logic [TW-1:0] T_END = TW'(SAMPLE_PERIOD - 1);
  localparam logic [DW-1:0] DWELL_MIN = DW'(CS_SETUP);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [TW-1:0] timer, timer_n;
  logic [DW-1:0] dwell, dwell_n;
  logic [LUX_W-1:0] shreg, result;
  logic pending, miso_s, start, sample, finish, cs_next, sclk_next, emit;
  sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d(spi_miso), .q(miso_s));
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    bit_n = bit_cnt;
    case (state)
      IDLE: begin
        cnt_n = '0;
        bit_n = '0;
        if (pending && enable && dwell >= DWELL_MIN) state_n = SETUP;
      end
      SETUP: if (cnt == SETUP_END) begin
        state_n = SHIFT;
        cnt_n = '0;
      end
      SHIFT: if (cnt == BIT_END) begin
        cnt_n = '0;
        bit_n = bit_cnt + 1'b1;
        if (bit_cnt == LAST_BIT) state_n = HOLD;
      end
      HOLD: if (cnt == HOLD_END) begin
        state_n = DONE;
        cnt_n = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n = '0;
      end
    endcase
  end
  assign start = state == IDLE && state_n == SETUP;
  assign sample = state == SHIFT && cnt == BIT_END;
  assign finish = state_n == DONE;
  assign cs_next = state_n == IDLE || state_n == DONE;
  assign sclk_next = state_n == SHIFT && cnt_n >= HALF;
  // timer free-runs with period SAMPLE_PERIOD so expiries keep landing during long frames
  assign timer_n = (start || timer == T_END) ? '0 : timer + 1'b1;
  // dwell counts cycles with cs_n high, saturating once the minimum high time is met
  assign dwell_n = !cs_next ? '0 : (dwell >= DWELL_MIN ? dwell : dwell + 1'b1);
  assign busy = !spi_cs_n;
`ifdef LUX_SPI_AVG_EN
  logic [ACC_W-1:0] acc, sum;
  logic [$clog2(AVG_FRAMES)-1:0] fcnt;
  logic last_frame;
  assign sum = acc + ACC_W'(shreg);
  assign last_frame = fcnt == $bits(fcnt)'(AVG_FRAMES - 1);
  assign emit = finish && last_frame;
  assign result = sum[ACC_W-1 -: LUX_W];
  always_ff @(posedge clk)
    if (!rst_n || (state == IDLE && !enable)) begin
      acc <= '0;
      fcnt <= '0;
    end else if (finish) begin
      acc <= last_frame ? '0 : sum;
      fcnt <= fcnt + 1'b1;
    end
`else
  assign emit = finish;
  assign result = shreg;
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      timer <= '0;
      pending <= 1'b1;
      dwell <= DWELL_MIN;
      shreg <= '0;
      spi_cs_n <= 1'b1;
      spi_sclk <= 1'b0;
      lux_out <= '0;
      data_valid <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_cnt <= bit_n;
      timer <= timer_n;
      pending <= start ? 1'b0 : (timer_n == T_END ? 1'b1 : pending);
      dwell <= dwell_n;
      spi_cs_n <= cs_next;
      spi_sclk <= sclk_next;
      data_valid <= emit;
      if (sample) shreg <= {shreg[LUX_W-2:0], miso_s};
      if (emit) lux_out <= result;
    end
endmodule

// File: tb/tb_lux_spi_reader.sv
// tb_lux_spi_reader: directed self-checking bench for lux_spi_reader with a mode-0 sensor model per instance
module tb_lux_spi_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n [2] = '{1'b0, 1'b0};
  logic enable [2] = '{1'b1, 1'b1};
  logic miso [2] = '{1'b0, 1'b0};
  logic sclk [2], cs_n [2], dv [2], busy [2];
  logic [15:0] lux [2];
  logic [15:0] word [2] = '{16'h1234, 16'hA5C3};
  logic [15:0] sh [2] = '{16'h0000, 16'h0000};
  logic alt [2] = '{1'b0, 1'b0};
  logic cs_d [2] = '{1'b1, 1'b1};
  logic sclk_d [2] = '{1'b0, 1'b0};
  int cyc = 0;
  int falls [2], rises [2], dvs [2], last_fall [2], last_dv [2], spacing [2], hi_len [2], rise_t [2];
  int vectors = 0, miscompares = 0;
`ifdef LUX_SPI_AVG_EN
  logic [15:0] seq [4] = '{16'h0010, 16'h0020, 16'h0030, 16'h0041};
`endif
  lux_spi_reader #(.SAMPLE_PERIOD(1000)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .enable(enable[0]), .spi_miso(miso[0]), .spi_sclk(sclk[0]),
    .spi_cs_n(cs_n[0]), .lux_out(lux[0]), .data_valid(dv[0]), .busy(busy[0]));
  lux_spi_reader #(.SAMPLE_PERIOD(50)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .enable(enable[1]), .spi_miso(miso[1]), .spi_sclk(sclk[1]),
    .spi_cs_n(cs_n[1]), .lux_out(lux[1]), .data_valid(dv[1]), .busy(busy[1]));
  always @(posedge clk) cyc++;
  // sensor model: loads its word when cs_n falls, shifts on each falling sclk, MSB first
  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      if (cs_d[i] && !cs_n[i]) begin
        falls[i]++;
        spacing[i] = cyc - last_fall[i];
        hi_len[i] = cyc - rise_t[i];
        last_fall[i] = cyc;
        sh[i] = alt[i] ? ((falls[i] % 2 == 1) ? 16'hFFFF : 16'h0000) : word[i];
      end else if (sclk_d[i] && !sclk[i]) sh[i] = sh[i] << 1;
      if (!cs_d[i] && cs_n[i]) rise_t[i] = cyc;
      if (!sclk_d[i] && sclk[i]) rises[i]++;
      if (dv[i] === 1'b1) begin
        dvs[i]++;
        last_dv[i] = cyc;
      end
      miso[i] = sh[i][15];
      cs_d[i] = cs_n[i];
      sclk_d[i] = sclk[i];
    end
  task automatic step(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_cnt(string tag, bit is_dv, int i, int n, int budget);
    int k = 0;
    while ((is_dv ? dvs[i] : falls[i]) < n && k < budget) begin
      step(1);
      k++;
    end
    chk(tag, 32'((is_dv ? dvs[i] : falls[i]) >= n), 32'd1);
  endtask
  initial begin
    int f, d;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("rst_cs_n", cs_n[0], 1);
      chk("rst_sclk", sclk[0], 0);
      chk("rst_lux", lux[0], 0);
      chk("rst_dv", dv[0], 0);
      chk("rst_busy", busy[0], 0);
    end
`ifdef LUX_SPI_AVG_EN
    word[0] = seq[0];
    rst_n = '{1'b1, 1'b1};
    for (int k = 1; k < 4; k++) begin
      wait_cnt("avg_fall", 0, 0, k, 1200);
      word[0] = seq[k];
    end
    wait_cnt("avg_fall4", 0, 0, 4, 1200);
    chk("avg_no_early_dv", dvs[0], 0);
    wait_cnt("avg_dv", 1, 0, 1, 300);
    chk("avg_lux", lux[0], 16'h0028);
    chk("avg_falls", falls[0], 4);
    step(1);
    chk("avg_dv_pulse", dv[0], 0);
`else
    rst_n = '{1'b1, 1'b1};
    step(20);
    chk("f0_cs_low", cs_n[0], 0);
    chk("f0_busy", busy[0], 1);
    wait_cnt("f0_dv_seen", 1, 0, 1, 300);
    chk("f0_lux", lux[0], 16'h1234);
    chk("f0_latency", last_dv[0] - last_fall[0], 134);
    chk("f0_rises", rises[0], 16);
    chk("f0_falls", falls[0], 1);
    chk("f0_dv_high", dv[0], 1);
    step(1);
    chk("f0_dv_pulse", dv[0], 0);
    chk("f0_busy_end", busy[0], 0);
    alt[0] = 1'b1;
    wait_cnt("p_fall2", 0, 0, 2, 1200);
    chk("p_space2", spacing[0], 1000);
    wait_cnt("p_dv2", 1, 0, 2, 300);
    chk("p_lux_zero", lux[0], 16'h0000);
    wait_cnt("p_fall3", 0, 0, 3, 1200);
    chk("p_space3", spacing[0], 1000);
    wait_cnt("p_dv3", 1, 0, 3, 300);
    chk("p_lux_ones", lux[0], 16'hFFFF);
    chk("p_rises", rises[0], 48);
    wait_cnt("o_dv", 1, 1, dvs[1] + 1, 300);
    chk("o_space", spacing[1], 136);
    chk("o_cs_high", hi_len[1], 2);
    chk("o_one_dv_per_frame", dvs[1], falls[1]);
    chk("o_lux", lux[1], 16'hA5C3);
    word[1] = 16'h0F0F;
    wait_cnt("e_fall", 0, 1, falls[1] + 1, 200);
    step(64);
    enable[1] = 1'b0;
    f = falls[1];
    d = dvs[1];
    step(200);
    chk("e_dv_once", dvs[1], d + 1);
    chk("e_no_new_frame", falls[1], f);
    chk("e_cs_high", cs_n[1], 1);
    chk("e_lux", lux[1], 16'h0F0F);
    enable[1] = 1'b1;
    step(1);
    chk("e_pending_kept", falls[1], f + 1);
    step(65);
    d = dvs[1];
    rst_n[1] = 1'b0;
    step(1);
    chk("r_cs_high", cs_n[1], 1);
    chk("r_sclk_low", sclk[1], 0);
    step(3);
    chk("r_no_dv", dvs[1], d);
    chk("r_lux_cleared", lux[1], 0);
    rst_n[1] = 1'b1;
    step(140);
    chk("r_restart_dv", dvs[1], d + 1);
    chk("r_restart_lux", lux[1], 16'h0F0F);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
